// File: rtl/bcd_scan_source.sv
// rtl/bcd_scan_source.sv - binary amount to packed BCD (double-dabble) with a free-running digit scanner
// The display register is only written on the final conversion iteration, so the scan never shows partial digits.
module bcd_scan_source #(
  parameter int WIDTH     = 27,
  parameter int MAX_VALUE = 99999999,
  parameter int DIGITS    = 8
) (
  input  logic             sclk_1ms,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] amount,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [2:0]       digit_sel,
  output logic [3:0]       LED_BCD,
  output logic             digit_blank
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    acc_q, acc_adj, acc_next, disp_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last_iter, too_big;

  logic [2:0]        sel_next;
  logic [DIGITS-1:0] upper_zero;
  logic              blank_next;
  logic [3:0]        digit_next;

  assign too_big   = (amount > MAX_V);
  assign accept    = (state == IDLE) && load;
  assign last_iter = (state == CONV) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  // Add-3 correction on every nibble before the shift, then pull in the next binary bit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BW-2:0], shift_q[WIDTH-1]};
  end

  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_iter;
      if (accept) begin
        shift_q  <= too_big ? MAX_V : amount;
        acc_q    <= '0;
        cnt_q    <= '0;
        overflow <= too_big;
      end else if (state == CONV) begin
        acc_q   <= acc_next;
        shift_q <= {shift_q[WIDTH-2:0], 1'b0};
        cnt_q   <= cnt_q + 1'b1;
        if (last_iter) disp_q <= acc_next;
      end
    end
  end

  // Outputs are computed for the position being entered, so they always match the registered digit_sel.
  assign sel_next = digit_sel + 3'd1;

  always_comb begin
    upper_zero = '0;
    for (int k = 0; k < DIGITS; k++) begin
      upper_zero[k] = ((disp_q >> (4 * k)) == '0);
    end
    blank_next = blank_lz && (sel_next != 3'd0) && upper_zero[sel_next];
    digit_next = disp_q[{sel_next, 2'b00} +: 4];
  end

  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      digit_sel   <= 3'd0;
      LED_BCD     <= 4'd0;
      digit_blank <= 1'b0;
    end else begin
      digit_sel   <= sel_next;
      digit_blank <= blank_next;
      LED_BCD     <= blank_next ? 4'hF : digit_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_source.sv
// tb/tb_bcd_scan_source.sv - scoreboard bench for bcd_scan_source
// Each load pushes the expected scanned frame; a monitor pops it on every done pulse.
module tb_bcd_scan_source;

  logic        sclk_1ms = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [26:0] amount = '0;
  logic        blank_lz = 1'b0;
  logic        busy, done, overflow, digit_blank;
  logic [2:0]  digit_sel;
  logic [3:0]  LED_BCD;

  int checks = 0;
  int fails = 0;
  int done_count = 0;

  typedef struct {
    logic [31:0] codes;
    logic [7:0]  blanks;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  bcd_scan_source dut (
    .sclk_1ms(sclk_1ms), .rst(rst), .load(load), .amount(amount), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow), .digit_sel(digit_sel),
    .LED_BCD(LED_BCD), .digit_blank(digit_blank)
  );

  always #5 sclk_1ms = ~sclk_1ms;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic capture_frame(output logic [31:0] codes, output logic [7:0] blanks);
    codes  = '0;
    blanks = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk_1ms);
      codes[int'(digit_sel)*4 +: 4] = LED_BCD;
      blanks[digit_sel] = digit_blank;
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] c;
    logic [7:0]  b;
    forever begin
      @(negedge sclk_1ms);
      if (done === 1'b1) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pulse");
        end else begin
          e = exp_q.pop_front();
          capture_frame(c, b);
          check("frame_codes", c, e.codes);
          check("frame_blanks", 32'(b), 32'(e.blanks));
          check("overflow", 32'(overflow), 32'(e.ov));
        end
      end
    end
  end

  task automatic run_load(input logic [26:0] a, input logic blz, input logic [31:0] codes,
                          input logic [7:0] blanks, input logic ov);
    int nb;
    blank_lz = blz;
    exp_q.push_back('{codes, blanks, ov});
    @(negedge sclk_1ms);
    load = 1'b1;
    amount = a;
    @(negedge sclk_1ms);
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge sclk_1ms);
    end
    check("busy_cycles", 32'(nb), 32'd27);
    check("done_after_busy", 32'(done), 32'd1);
    repeat (10) @(negedge sclk_1ms);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] c;
    logic [7:0]  b;
    int          d0;

    repeat (3) @(negedge sclk_1ms);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_led", 32'(LED_BCD), 32'd0);
    check("rst_blank", 32'(digit_blank), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge sclk_1ms);
      check("scan_sel", 32'(digit_sel), 32'(i % 8));
      check("scan_led_zero", 32'(LED_BCD), 32'd0);
    end

    run_load(27'd12345678, 1'b0, 32'h12345678, 8'h00, 1'b0);
    run_load(27'd1000,     1'b1, 32'hFFFF1000, 8'hF0, 1'b0);
    run_load(27'd0,        1'b1, 32'hFFFFFFF0, 8'hFE, 1'b0);
    run_load(27'd100000000, 1'b0, 32'h99999999, 8'h00, 1'b1);
    run_load(27'd5,        1'b0, 32'h00000005, 8'h00, 1'b0);
    run_load(27'd12345678, 1'b0, 32'h12345678, 8'h00, 1'b0);

    // Second load mid-conversion must be dropped; old digits stay up until commit.
    d0 = done_count;
    exp_q.push_back('{32'h00000042, 8'h00, 1'b0});
    @(negedge sclk_1ms);
    load = 1'b1;
    amount = 27'd42;
    @(negedge sclk_1ms);
    load = 1'b0;
    repeat (4) @(negedge sclk_1ms);
    load = 1'b1;
    amount = 27'd7;
    @(negedge sclk_1ms);
    load = 1'b0;
    capture_frame(c, b);
    check("hold_display", c, 32'h12345678);
    check("hold_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 40 && busy === 1'b1; n++) @(negedge sclk_1ms);
    repeat (12) @(negedge sclk_1ms);
    check("single_done", 32'(done_count - d0), 32'd1);
    check("ignored_busy", 32'(busy), 32'd0);

    // Reset during conversion aborts it and clears the display.
    d0 = done_count;
    @(negedge sclk_1ms);
    load = 1'b1;
    amount = 27'd12345678;
    @(negedge sclk_1ms);
    load = 1'b0;
    repeat (9) @(negedge sclk_1ms);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sel", 32'(digit_sel), 32'd0);
    check("abort_led", 32'(LED_BCD), 32'd0);
    @(negedge sclk_1ms);
    rst = 1'b0;
    capture_frame(c, b);
    check("abort_display", c, 32'h00000000);
    check("abort_blanks", 32'(b), 32'd0);
    repeat (40) @(negedge sclk_1ms);
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_source.md
Name: bcd_scan_source

Overview:
Upstream feeder for the seven-segment display driver. It accepts a binary ATM amount (balance or withdrawal) through a load handshake and converts it to 8 packed BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits, one per sclk_1ms cycle, onto LED_BCD/digit_sel, with optional leading-zero blanking. The display register is updated atomically, so the scan never shows a half-converted value.

Parameters:
WIDTH, 27, binary input width; one conversion iteration per input bit.
MAX_VALUE, 99999999, largest displayable value; inputs above it saturate.
DIGITS, 8, number of BCD digits and scan positions; fixed at 8 in this revision, with digit_sel 3 bits wide.

Ports:
sclk_1ms      input   1      scan/conversion clock, 1 kHz; all logic on its rising edge
rst           input   1      reset, asynchronous, active-high
load          input   1      request conversion of amount; sampled each edge
amount        input   27     unsigned binary value to display
blank_lz      input   1      1 = blank leading zeros
busy          output  1      conversion in progress; load ignored while high
done          output  1      one-cycle pulse when new digits are committed
overflow      output  1      last accepted amount exceeded MAX_VALUE
digit_sel     output  3      scan position, 0 = least significant digit
LED_BCD       output  4      BCD nibble for digit_sel; 4'hF = blank code
digit_blank   output  1      1 when the current position is blanked

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - busy=0, done=0, overflow=0.
  - Display register=0, digit_sel=0, LED_BCD=0, digit_blank=0.
  - Iteration counter=0; FSM=IDLE.
- FSM has two states, IDLE and CONV.
- IDLE, load accepted only when busy=0 at the sampling edge (edge N):
  - Latch sat = (amount > MAX_VALUE) ? MAX_VALUE : amount into the shift register; clear the 32-bit BCD accumulator; clear cnt.
  - overflow <= (amount > MAX_VALUE); busy <= 1; go to CONV.
- CONV, edges N+1..N+27, one iteration per edge:
  - Every accumulator nibble >= 5 gets +3.
  - Then {acc, shift} shifts left by 1, with the MSB of shift entering acc[0].
  - cnt increments each iteration.
  - On the iteration with cnt == WIDTH-1 (edge N+27):
    - Display register <= final accumulator, including that iteration.
    - busy <= 0; done <= 1 for exactly one cycle; go to IDLE.
- busy is high for exactly 27 cycles.
- load while busy=1 is ignored: no queueing and no effect on overflow.
- A new load can be accepted on edge N+28, the first edge with busy=0.
- The display register holds the previous value for the whole conversion.
- Scanner, free-running every edge, independent of the FSM:
  - digit_sel increments and wraps 7 -> 0.
  - LED_BCD and digit_blank are registered alongside digit_sel and always describe the registered digit_sel value in the same cycle.
  - New digits first appear on the edge after the commit (from edge N+28).
- Leading-zero blanking: position k (k >= 1) is blanked when blank_lz=1 and digits k..7 are all zero.
  - When blanked: LED_BCD=4'hF, digit_blank=1.
  - Position 0 is never blanked, so value 0 shows a single "0".
  - A blank_lz change takes effect at the next scan update.
- Reset mid-conversion aborts the conversion: busy=0, no done pulse, display cleared to 0.

Test Plan:
- Release reset, load=0 -> all outputs 0; digit_sel steps 0,1,...,7,0 each cycle; LED_BCD=0 throughout.
- load=1 with amount=12345678 at edge N -> busy high edges N..N+26 (27 cycles); done pulses after edge N+27; from N+28 positions 0..7 show 8,7,6,5,4,3,2,1; overflow=0.
- blank_lz=1, amount=1000 -> positions 0..3 show 0,0,0,1 and positions 4..7 show 4'hF with digit_blank=1; then amount=0 -> position 0 shows 0 unblanked, positions 1..7 blank.
- amount=100000000 -> overflow=1 and all 8 positions show 9; next load of amount=5 -> overflow=0, position 0 shows 5.
- Display holds 12345678, load amount=42, then pulse load with amount=7 at N+5 -> second load ignored; 12345678 displayed until the commit, then 00000042; done pulses exactly once.
- Assert rst at N+10 during conversion of 12345678 -> busy=0, done never pulses, all positions show 0, digit_sel=0.
